// File: rtl/section1_4bit_up_counter_pkg.sv
// Shared constants and helpers for the free-running up-counter.
package section1_4bit_up_counter_pkg;

    localparam int unsigned DEFAULT_DATA_SIZE = 4;

    // All-ones terminal value for a counter of the given width (1..32).
    function automatic logic [31:0] all_ones(input int unsigned width);
        return 32'((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/section1_4bit_up_counter_core.sv
// Generic register-plus-incrementer; wraps modulo 2^WIDTH, async active-high clear.
module section1_4bit_up_counter_core
    import section1_4bit_up_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DATA_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/section1_4bit_up_counter.sv
// Free-running up-counter with terminal-count decode; reset_n is active-high.
module section1_4bit_up_counter
    import section1_4bit_up_counter_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [DATA_SIZE-1:0] q_out,
    output logic                 tc_out
);

    localparam logic [DATA_SIZE-1:0] TERMINAL = DATA_SIZE'(all_ones(DATA_SIZE));

    section1_4bit_up_counter_core #(
        .WIDTH (DATA_SIZE)
    ) u_core (
        .clk   (clk),
        .rst   (reset_n),
        .count (q_out)
    );

    // Decoded straight from the count register, so it is low whenever reset holds q_out at 0.
    assign tc_out = (q_out == TERMINAL);

endmodule

// File: tb/tb_section1_4bit_up_counter.sv
// Directed self-checking bench for section1_4bit_up_counter (default width and width 3).
module tb_section1_4bit_up_counter;

    logic       clk;
    logic       reset_n;
    logic [3:0] q_out;
    logic       tc_out;
    logic       reset3;
    logic [2:0] q3;
    logic       tc3;

    int total;
    int bad;

    section1_4bit_up_counter u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q_out   (q_out),
        .tc_out  (tc_out)
    );

    section1_4bit_up_counter #(
        .DATA_SIZE (3)
    ) u_dut3 (
        .clk     (clk),
        .reset_n (reset3),
        .q_out   (q3),
        .tc_out  (tc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n = 1'b1;
        reset3  = 1'b1;
        #1;
        total++;
        if (q_out !== 4'd0 || tc_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_immediate: q_out=%0h tc_out=%0b, want q_out=0 tc_out=0", q_out, tc_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (q_out !== 4'd0 || tc_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_held[%0d]: q_out=%0h tc_out=%0b, want q_out=0 tc_out=0", i, q_out, tc_out);
            end
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (q_out !== 4'd0) begin
            bad++;
            $display("FAIL release_no_edge: q_out=%0h, want 0", q_out);
        end
        @(posedge clk);
        #1;
        total++;
        if (q_out !== 4'd1 || tc_out !== 1'b0) begin
            bad++;
            $display("FAIL first_count: q_out=%0h tc_out=%0b, want q_out=1 tc_out=0", q_out, tc_out);
        end
    endtask

    // Continues from q_out=1: 19 more edges give 2..15,0,1,2,3,4.
    task automatic test_full_sequence();
        logic [3:0] exp_q;
        exp_q = 4'd1;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk);
            #1;
            exp_q = exp_q + 4'd1;
            total++;
            if (q_out !== exp_q || tc_out !== (exp_q == 4'd15)) begin
                bad++;
                $display("FAIL full_seq[%0d]: q_out=%0h tc_out=%0b, want q_out=%0h tc_out=%0b",
                         i, q_out, tc_out, exp_q, (exp_q == 4'd15));
            end
        end
        total++;
        if (q_out !== 4'd4) begin
            bad++;
            $display("FAIL full_seq_end: q_out=%0h, want 4", q_out);
        end
    endtask

    task automatic test_async_mid_count();
        int guard;
        guard = 0;
        while (q_out !== 4'd9 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (q_out !== 4'd9) begin
            bad++;
            $display("FAIL reach_nine: q_out=%0h after %0d cycles, want 9", q_out, guard);
        end
        #1;
        reset_n = 1'b1;
        #1;
        total++;
        if (q_out !== 4'd0 || tc_out !== 1'b0) begin
            bad++;
            $display("FAIL async_clear: q_out=%0h tc_out=%0b, want q_out=0 tc_out=0", q_out, tc_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (q_out !== 4'd0) begin
                bad++;
                $display("FAIL async_hold[%0d]: q_out=%0h, want 0", i, q_out);
            end
        end
    endtask

    // Nonblocking drive makes the release land after the flop samples this edge.
    task automatic test_release_on_edge();
        @(posedge clk);
        reset_n <= 1'b0;
        #1;
        total++;
        if (q_out !== 4'd0) begin
            bad++;
            $display("FAIL edge_release_same: q_out=%0h, want 0", q_out);
        end
        @(posedge clk);
        #1;
        total++;
        if (q_out !== 4'd1) begin
            bad++;
            $display("FAIL edge_release_next: q_out=%0h, want 1", q_out);
        end
    endtask

    // 100 cycles, reset toggling every 16 cycles starting deasserted.
    task automatic test_periodic_reset();
        logic [3:0] exp_q;
        logic       rst_lvl;
        reset_n = 1'b1;
        @(negedge clk);
        exp_q = 4'd0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            rst_lvl = ((cyc / 16) % 2) == 1;
            reset_n = rst_lvl;
            if (cyc % 16 == 0 && rst_lvl) begin
                #1;
                total++;
                if (q_out !== 4'd0) begin
                    bad++;
                    $display("FAIL periodic_assert[%0d]: q_out=%0h, want 0", cyc, q_out);
                end
            end
            @(posedge clk);
            #1;
            exp_q = rst_lvl ? 4'd0 : exp_q + 4'd1;
            total++;
            if (q_out !== exp_q || tc_out !== (exp_q == 4'd15)) begin
                bad++;
                $display("FAIL periodic[%0d]: q_out=%0h tc_out=%0b, want q_out=%0h tc_out=%0b",
                         cyc, q_out, tc_out, exp_q, (exp_q == 4'd15));
            end
            @(negedge clk);
        end
        total++;
        if (q_out !== 4'd4) begin
            bad++;
            $display("FAIL periodic_end: q_out=%0h, want 4", q_out);
        end
    endtask

    task automatic test_width3();
        logic [2:0] exp_q;
        total++;
        if (q3 !== 3'd0 || tc3 !== 1'b0) begin
            bad++;
            $display("FAIL w3_reset: q=%0h tc=%0b, want q=0 tc=0", q3, tc3);
        end
        @(negedge clk);
        reset3 = 1'b0;
        exp_q  = 3'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            exp_q = exp_q + 3'd1;
            total++;
            if (q3 !== exp_q || tc3 !== (exp_q == 3'd7)) begin
                bad++;
                $display("FAIL w3_seq[%0d]: q=%0h tc=%0b, want q=%0h tc=%0b",
                         i, q3, tc3, exp_q, (exp_q == 3'd7));
            end
        end
        @(negedge clk);
        reset3 = 1'b1;
        #1;
        total++;
        if (q3 !== 3'd0) begin
            bad++;
            $display("FAIL w3_async_clear: q=%0h, want 0", q3);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_full_sequence();
        test_async_mid_count();
        test_release_on_edge();
        test_periodic_reset();
        test_width3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
